// File: rtl/keypad_encoder_db_if.sv
// Keypad encoder bus: raw key lines and controls in, code/entry buffer out.
interface keypad_encoder_db_if #(
  parameter int N_KEYS = 10,
  parameter int CODE_W = 4,
  parameter int DIGITS = 4
);
  localparam int CW = $clog2(DIGITS + 1);

  logic [N_KEYS-1:0]        keys;
  logic                     en;
  logic                     clear;
  logic [CODE_W-1:0]        code;
  logic                     key_valid;
  logic                     err;
  logic [DIGITS*CODE_W-1:0] digits;
  logic [CW-1:0]            count;
  logic                     full;

  // Panel side: drives key lines and controls, observes the entry state.
  modport master (
    output keys, en, clear,
    input  code, key_valid, err, digits, count, full
  );

  // Encoder side.
  modport slave (
    input  keys, en, clear,
    output code, key_valid, err, digits, count, full
  );
endinterface

// File: rtl/keypad_encoder_db.sv
// Debounced one-hot keypad encoder with multi-key rejection and a digit
// entry buffer. One accepted digit per physical press; a full release is
// needed before the next press is considered.
module keypad_encoder_db #(
  parameter int N_KEYS    = 10,
  parameter int CODE_W    = 4,
  parameter int DB_CYCLES = 4,
  parameter int DIGITS    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  keypad_encoder_db_if.slave bus
);
  localparam int DW  = DIGITS * CODE_W;
  localparam int CW  = $clog2(DIGITS + 1);
  localparam int DBW = $clog2(DB_CYCLES + 1);

  // Counter value seen when the sample being consumed is the last one needed.
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HOLD     = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [N_KEYS-1:0] r_key_q;
  logic [N_KEYS-1:0] r_cand, w_cand_nxt;
  logic [DBW-1:0]    r_cnt, w_cnt_nxt;
  logic [DBW-1:0]    r_rcnt, w_rcnt_nxt;
  logic [CODE_W-1:0] r_code;
  logic              r_key_valid;
  logic              r_err;
  logic [DW-1:0]     r_digits;
  logic [CW-1:0]     r_count;

  logic              w_none, w_single, w_multi;
  logic              w_accept, w_err;
  logic [CODE_W-1:0] w_acc_code;

  // Binary index of the (single) set bit; zero when nothing is set.
  function automatic logic [CODE_W-1:0] f_index(input logic [N_KEYS-1:0] v);
    logic [CODE_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_KEYS; i++)
      if (v[i]) r = CODE_W'(i);
    return r;
  endfunction

  // Classify the registered sample. Clearing the lowest set bit leaves zero
  // only for a one-hot value.
  always_comb begin
    w_none   = (r_key_q == '0);
    w_single = !w_none && ((r_key_q & (r_key_q - 1'b1)) == '0);
    w_multi  = !w_none && !w_single;
  end

  // Any accept happens while key_q equals the candidate, so encode key_q.
  assign w_acc_code = f_index(r_key_q);

  // Single register stage on the asynchronous key lines.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_key_q <= '0;
    else       r_key_q <= bus.keys;
  end

  // FSM state and debounce/release counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_rcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rcnt  <= w_rcnt_nxt;
    end
  end

  // Next-state: debounce a single key, reject multi-key, wait for release.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_rcnt_nxt  = r_rcnt;
    w_accept    = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.en && w_single) begin
          w_cand_nxt = r_key_q;
          w_cnt_nxt  = DBW'(1);
          if (DB_CYCLES == 1) w_accept    = 1'b1;
          else                w_state_nxt = S_DEBOUNCE;
        end else if (bus.en && w_multi) begin
          w_err       = 1'b1;
          w_state_nxt = S_HOLD;
          w_rcnt_nxt  = '0;
        end
      end
      S_DEBOUNCE: begin
        if (!bus.en) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_key_q == r_cand) begin
          if (r_cnt == DB_LAST) w_accept  = 1'b1;
          else                  w_cnt_nxt = r_cnt + 1'b1;
        end else if (w_multi) begin
          w_err       = 1'b1;
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
          w_rcnt_nxt  = '0;
        end else begin
          // Released or rolled onto another key: start over from idle.
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      S_HOLD: begin
        // Only a run of DB_CYCLES empty samples re-arms the encoder.
        if (w_none) begin
          if (r_rcnt == DB_LAST) begin
            w_state_nxt = S_IDLE;
            w_rcnt_nxt  = '0;
          end else begin
            w_rcnt_nxt = r_rcnt + 1'b1;
          end
        end else begin
          w_rcnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_rcnt_nxt  = '0;
      end
    endcase
    if (w_accept) begin
      w_state_nxt = S_HOLD;
      w_cnt_nxt   = '0;
      w_rcnt_nxt  = '0;
    end
  end

  // Output pulses and last accepted code.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_code      <= '1;
      r_key_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_key_valid <= w_accept;
      r_err       <= w_err;
      if (w_accept) r_code <= w_acc_code;
    end
  end

  // Entry buffer: newest digit in the LSBs; clear wins over old contents
  // but still keeps a digit accepted on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_digits <= '0;
      r_count  <= '0;
    end else if (bus.clear) begin
      if (w_accept) begin
        r_digits <= DW'(w_acc_code);
        r_count  <= CW'(1);
      end else begin
        r_digits <= '0;
        r_count  <= '0;
      end
    end else if (w_accept) begin
      r_digits <= (r_digits << CODE_W) | DW'(w_acc_code);
      if (r_count != FULL_CNT) r_count <= r_count + 1'b1;
    end
  end

  assign bus.code      = r_code;
  assign bus.key_valid = r_key_valid;
  assign bus.err       = r_err;
  assign bus.digits    = r_digits;
  assign bus.count     = r_count;
  assign bus.full      = (r_count == FULL_CNT);

endmodule

// File: doc/keypad_encoder_db.md
Name: keypad_encoder_db

Overview:
Clocked, parametrised successor to the combinational one-hot keypad encoder for the microwave control panel. It synchronises and debounces the one-hot key lines and rejects multi-key presses. Each accepted key produces one binary code and a single-cycle valid pulse, and the digit is shifted into an entry buffer that the timer-load logic reads. Each physical press yields exactly one digit, and a full release is required before the next digit is accepted.

Parameters:
N_KEYS, 10, number of one-hot key lines; key i encodes to value i.
CODE_W, 4, code width; must satisfy N_KEYS <= 2**CODE_W - 1 (all-ones is reserved as "no key").
DB_CYCLES, 4, consecutive identical samples needed to accept a press or a release; minimum 1.
DIGITS, 4, entry buffer depth in digits.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
keys  in  N_KEYS  raw one-hot key lines, asynchronous to clk.
en  in  1  active-high accept enable (for example, low while cooking).
clear  in  1  synchronous clear of the entry buffer.
code  out  CODE_W  last accepted key code; all-ones after reset.
key_valid  out  1  one-cycle pulse when a key is accepted.
err  out  1  one-cycle pulse when a multi-key press is detected.
digits  out  DIGITS*CODE_W  entry buffer; newest digit in [CODE_W-1:0].
count  out  clog2(DIGITS+1)  number of digits held; saturates at DIGITS.
full  out  1  high when count == DIGITS.

Behaviour:
- Reset (rst high at a rising edge):
  - key_q = 0, state = IDLE, counters = 0.
  - code = all-ones; key_valid = 0; err = 0; digits = 0; count = 0; full = 0.
  - Reset overrides every other input, including mid-debounce and mid-hold.
- Input sampling: keys is registered once into key_q. All decisions use key_q.
- Classifying key_q:
  - "single": exactly one bit set.
  - "multi": two or more bits set.
  - "none": zero.
- State IDLE:
  - en = 1 and single: latch cand = key_q, cnt = 1, go to DEBOUNCE. If DB_CYCLES = 1, accept on this same edge.
  - en = 1 and multi: pulse err, go to HOLD.
  - Otherwise stay in IDLE.
- State DEBOUNCE:
  - en = 0: go to IDLE with no output.
  - key_q == cand: cnt++. The edge that consumes the DB_CYCLES-th identical sample performs the accept.
  - key_q is multi: pulse err, go to HOLD.
  - key_q is none, or a different single: go to IDLE with no output.
- Accept (registered, same edge):
  - code = index of cand.
  - key_valid = 1 for one cycle.
  - digits shift left by CODE_W, new code enters the LSBs, oldest digit drops out.
  - count = min(count+1, DIGITS).
  - Go to HOLD.
  - Latency: key_valid is high after edge DB_CYCLES+1, counting the edge that first registers the stable keys as edge 1.
- State HOLD:
  - rcnt counts consecutive none samples; any nonzero sample resets rcnt to 0.
  - The edge consuming the DB_CYCLES-th consecutive none sample goes to IDLE.
  - en has no effect in HOLD.
  - A multi-key sample in HOLD does not pulse err.
- clear (when not in reset):
  - digits = 0, count = 0.
  - If an accept occurs on the same edge: digits = new code in the LSBs only, count = 1.
  - clear does not change the FSM state or code.
- full is combinational from count.
- While full, accepts still shift; the oldest digit is lost (wrap behaviour); count stays at DIGITS.
- key_valid and err are never high in the same cycle.

Test Plan:
1. Reset, then hold keys = 10'b0000001000 for 6 cycles, then release for 6 cycles → one key_valid pulse at edge 5; code = 3; digits = 16'h0003; count = 1; err never asserted.
2. Bounce: keys = 10'b0000100000 for 2 cycles, 0 for 1, then stable for 5 → no pulse during the bounce; exactly one key_valid with code = 5, at edge 5 of the stable run.
3. Multi-key: keys = 10'b0000000110 held → err pulses once, key_valid stays 0; after release for ≥4 cycles, key 9 is accepted normally with code = 9.
4. Press 1, 2, 3, 4, 5 with full releases between presses → digits = 16'h2345; count = 4; full = 1; oldest digit 1 is dropped.
5. clear asserted on the same edge as the accept of key 7 (buffer holding 16'h1234) → digits = 16'h0007; count = 1; code = 7.
6. en = 0 for a 10-cycle press of key 2 → no key_valid or err. With en raised mid-press, the press is accepted 4 edges after en rises. rst asserted at the accept edge → all outputs return to reset values, with code = 4'b1111.
